// File: rtl/conv_mon_pkg.sv
// conv_mon_pkg: shared FSM type, violation counter limits and channel slicing helper
package conv_mon_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, REPORT} state_t;

    localparam int VIOL_W = 16;
    localparam logic [VIOL_W-1:0] VIOL_MAX = '1;

    // Packed vectors are zero-extended to this width before slicing (8 channels x 32 bits max)
    localparam int MAX_DATA_W = 32;
    localparam int MAX_VEC_W  = 8 * MAX_DATA_W;

    // Returns channel i of a packed vector with w-bit lanes; caller truncates to its lane width
    function automatic logic [MAX_DATA_W-1:0] ch_slice(input logic [MAX_VEC_W-1:0] vec, input int i, input int w);
        return MAX_DATA_W'(vec >> (i * w));
    endfunction

endpackage

// File: rtl/conv_window_monitor_cmp.sv
// conv_win_cmp: registered signed inclusive window compare for one channel (lo > hi never matches)
module conv_win_cmp #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] lo,
    input  logic signed [DATA_W-1:0] hi,
    output logic                     in_win
);

    logic in_win_d, in_win_q;

    // Inclusive signed bounds check
    always_comb in_win_d = (sample >= lo) && (sample <= hi);

    // Result is seen by the monitor one cycle after the sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_win_q <= 1'b0;
        else     in_win_q <= in_win_d;
    end

    assign in_win = in_win_q;

endmodule

// File: rtl/conv_window_monitor.sv
// conv_window_monitor: settle, then require all channels in window for a hold period; report pass/fail.
// Optional CONV_MON_ORDER_CHK_EN adds an ordering check sample[0] > sample[1] during HOLD.
module conv_window_monitor
    import conv_mon_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int SETTLE_CYC = 2000000,
    parameter int HOLD_CYC   = 4096,
    parameter int CNT_W      = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_CH*DATA_W-1:0]   sample,
    input  logic [NUM_CH*DATA_W-1:0]   lo_lim,
    input  logic [NUM_CH*DATA_W-1:0]   hi_lim,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [NUM_CH-1:0]          fail_mask,
    output logic [$clog2(NUM_CH)-1:0]  first_ch,
    output logic [VIOL_W-1:0]          viol_cnt
`ifdef CONV_MON_ORDER_CHK_EN
    ,
    input  logic                       order_en,
    output logic                       order_fail
`endif
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pass_q, pass_d;
    logic [NUM_CH-1:0]   fail_mask_q, fail_mask_d;
    logic [CH_W-1:0]     first_ch_q, first_ch_d;
    logic [VIOL_W-1:0]   viol_cnt_q, viol_cnt_d;
    logic                order_fail_q, order_fail_d;
    logic [NUM_CH-1:0]   in_win, bad;
    logic [CH_W-1:0]     low_idx;
    logic                order_bad, any_bad, settle_end, hold_end;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        conv_win_cmp #(.DATA_W(DATA_W)) u_cmp (
            .clk    (clk),
            .rst    (rst),
            .sample (DATA_W'(ch_slice(MAX_VEC_W'(sample), i, DATA_W))),
            .lo     (DATA_W'(ch_slice(MAX_VEC_W'(lo_lim), i, DATA_W))),
            .hi     (DATA_W'(ch_slice(MAX_VEC_W'(hi_lim), i, DATA_W))),
            .in_win (in_win[i])
        );
    end

`ifdef CONV_MON_ORDER_CHK_EN
    logic order_ok_d, order_ok_q;

    // Ordering compare is registered so it lines up with the window compare latency
    always_comb order_ok_d = $signed(DATA_W'(ch_slice(MAX_VEC_W'(sample), 0, DATA_W))) >
                             $signed(DATA_W'(ch_slice(MAX_VEC_W'(sample), 1, DATA_W)));

    // Ordering result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) order_ok_q <= 1'b0;
        else     order_ok_q <= order_ok_d;
    end

    assign order_bad  = (state_q == HOLD) && order_en && !order_ok_q;
    assign order_fail = order_fail_q;
`else
    assign order_bad = 1'b0;
`endif

    assign bad        = (state_q == HOLD) ? ~in_win : '0;
    assign any_bad    = (bad != '0) || order_bad;
    assign settle_end = cnt_q == CNT_W'(SETTLE_CYC - 1);
    assign hold_end   = cnt_q == CNT_W'(HOLD_CYC - 1);

    // Lowest violating channel index this cycle
    always_comb begin
        low_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) if (bad[k]) low_idx = CH_W'(k);
    end

    // Check sequencing and diagnostic accumulation; abort outranks everything outside IDLE
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        fail_mask_d  = fail_mask_q;
        first_ch_d   = first_ch_q;
        viol_cnt_d   = viol_cnt_q;
        order_fail_d = order_fail_q;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (start && !abort) begin
                state_d      = SETTLE;
                cnt_d        = '0;
                pass_d       = 1'b0;
                fail_mask_d  = '0;
                first_ch_d   = '0;
                viol_cnt_d   = '0;
                order_fail_d = 1'b0;
            end
        end else if (state_q == SETTLE) begin
            state_d = settle_end ? HOLD : SETTLE;
            cnt_d   = settle_end ? '0 : cnt_q + CNT_W'(1);
        end else if (state_q == HOLD) begin
            fail_mask_d  = fail_mask_q | bad;
            order_fail_d = order_fail_q | order_bad;
            first_ch_d   = (fail_mask_q == '0 && bad != '0) ? low_idx : first_ch_q;
            viol_cnt_d   = (any_bad && viol_cnt_q != VIOL_MAX) ? viol_cnt_q + VIOL_W'(1) : viol_cnt_q;
            pass_d       = hold_end ? (fail_mask_d == '0 && !order_fail_d) : pass_q;
            state_d      = hold_end ? REPORT : HOLD;
            cnt_d        = hold_end ? '0 : cnt_q + CNT_W'(1);
        end else begin
            state_d = IDLE;
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pass_q       <= 1'b0;
            fail_mask_q  <= '0;
            first_ch_q   <= '0;
            viol_cnt_q   <= '0;
            order_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            fail_mask_q  <= fail_mask_d;
            first_ch_q   <= first_ch_d;
            viol_cnt_q   <= viol_cnt_d;
            order_fail_q <= order_fail_d;
        end
    end

    assign busy      = (state_q == SETTLE) || (state_q == HOLD);
    assign done      = state_q == REPORT;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign first_ch  = first_ch_q;
    assign viol_cnt  = viol_cnt_q;

endmodule

// File: tb/tb_conv_window_monitor.sv
// tb_conv_window_monitor: directed and randomized checks of conv_window_monitor against a behavioural model
module tb_conv_window_monitor;

    localparam int NC  = 3;
    localparam int DW  = 16;
    localparam int SC  = 16;
    localparam int HC  = 32;
    localparam int TOT = SC + HC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [NC*DW-1:0] sample, lo_lim, hi_lim;
    logic busy, done, pass;
    logic [NC-1:0] fail_mask;
    logic [1:0] first_ch;
    logic [15:0] viol_cnt;

    logic s_start = 1'b0;
    logic s_busy, s_done, s_pass;
    logic [NC-1:0] s_fail_mask;
    logic [1:0] s_first_ch;
    logic [15:0] s_viol_cnt;
    logic [NC*DW-1:0] s_sample = '0;
    logic [NC*DW-1:0] s_lo = {NC{16'sd1}};
    logic [NC*DW-1:0] s_hi = {NC{16'hFFFF}};

`ifdef CONV_MON_ORDER_CHK_EN
    logic order_en = 1'b0;
    logic order_fail;
    logic s_order_fail;
`endif

    int checks = 0;
    int failures = 0;
    int samp [0:TOT][0:NC-1];
    int lo_v [0:NC-1];
    int hi_v [0:NC-1];
    bit order_en_v = 1'b0;

    always #5 clk = ~clk;

    conv_window_monitor #(.NUM_CH(NC), .DATA_W(DW), .SETTLE_CYC(SC), .HOLD_CYC(HC), .CNT_W(22)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sample(sample), .lo_lim(lo_lim), .hi_lim(hi_lim),
        .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .first_ch(first_ch), .viol_cnt(viol_cnt)
`ifdef CONV_MON_ORDER_CHK_EN
        , .order_en(order_en), .order_fail(order_fail)
`endif
    );

    conv_window_monitor #(.NUM_CH(NC), .DATA_W(DW), .SETTLE_CYC(SC), .HOLD_CYC(70000), .CNT_W(22)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .abort(1'b0),
        .sample(s_sample), .lo_lim(s_lo), .hi_lim(s_hi),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_mask(s_fail_mask), .first_ch(s_first_ch), .viol_cnt(s_viol_cnt)
`ifdef CONV_MON_ORDER_CHK_EN
        , .order_en(1'b0), .order_fail(s_order_fail)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n);
        for (int c = 0; c < NC; c++) sample[c*DW +: DW] = DW'(samp[n][c]);
    endtask

    task automatic apply_lims();
        for (int c = 0; c < NC; c++) begin
            lo_lim[c*DW +: DW] = DW'(lo_v[c]);
            hi_lim[c*DW +: DW] = DW'(hi_v[c]);
        end
    endtask

    task automatic set_lims(input int lo, input int hi);
        for (int c = 0; c < NC; c++) begin
            lo_v[c] = lo;
            hi_v[c] = hi;
        end
    endtask

    task automatic fill_const(input int v0, input int v1, input int v2);
        for (int n = 0; n <= TOT; n++) begin
            samp[n][0] = v0;
            samp[n][1] = v1;
            samp[n][2] = v2;
        end
    endtask

    task automatic fill_rand(input int vp);
        int r;
        for (int c = 0; c < NC; c++) begin
            lo_v[c] = -int'($urandom_range(400, 0));
            hi_v[c] = int'($urandom_range(400, 0));
        end
        for (int n = 0; n <= TOT; n++)
            for (int c = 0; c < NC; c++) begin
                r = int'($urandom_range(vp - 1, 0));
                samp[n][c] = (r == 0) ? lo_v[c] - 1 - int'($urandom_range(50, 0)) :
                             (r == 1) ? hi_v[c] + 1 + int'($urandom_range(50, 0)) :
                             (r == 2) ? lo_v[c] :
                             (r == 3) ? hi_v[c] :
                             lo_v[c] + int'($urandom_range(hi_v[c] - lo_v[c], 0));
            end
    endtask

    // A complete check: samples driven after start cycle n are judged in HOLD cycles, i.e. n = SC-1 .. TOT-2
    task automatic run_check(input string tag, input int restart_at);
        logic [NC-1:0] em, bad;
        int ev, ef;
        bit eo, ob, seen;
        em = '0; ev = 0; ef = 0; eo = 0; seen = 0;
        for (int n = SC - 1; n <= TOT - 2; n++) begin
            for (int c = 0; c < NC; c++) bad[c] = (samp[n][c] < lo_v[c]) || (samp[n][c] > hi_v[c]);
            ob = order_en_v && !(samp[n][0] > samp[n][1]);
            if (bad != '0 && !seen) begin
                seen = 1;
                for (int c = NC - 1; c >= 0; c--) if (bad[c]) ef = c;
            end
            em |= bad;
            eo |= ob;
            if (bad != '0 || ob) ev++;
        end
        @(negedge clk);
        apply_lims();
        drive(0);
        start = 1'b1;
        for (int n = 0; n <= TOT; n++) begin
            @(negedge clk);
            start = (n == restart_at);
            drive(n);
            chk({tag, "_busy"}, busy, n < TOT);
            chk({tag, "_done"}, done, n == TOT);
        end
        chk({tag, "_pass"}, pass, (em == '0) && !eo);
        chk({tag, "_fail_mask"}, fail_mask, em);
        chk({tag, "_first_ch"}, first_ch, ef);
        chk({tag, "_viol_cnt"}, viol_cnt, ev);
`ifdef CONV_MON_ORDER_CHK_EN
        chk({tag, "_order_fail"}, order_fail, eo);
`endif
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done_after"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_pass_held"}, pass, (em == '0) && !eo);
    endtask

    task automatic start_run(input int upto, input int abort_at);
        @(negedge clk);
        apply_lims();
        drive(0);
        start = 1'b1;
        for (int n = 0; n <= upto; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (n == abort_at);
            drive(n);
        end
    endtask

    initial begin
        int dcnt;
        bit to;
        sample = '0;
        lo_lim = '0;
        hi_lim = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_mask", fail_mask, 0);
        chk("rst_first_ch", first_ch, 0);
        chk("rst_viol_cnt", viol_cnt, 0);
        rst = 1'b0;

        set_lims(-300, 300);
        fill_const(0, 0, 0);
        run_check("pass", -1);

        samp[20][1] = 301;
        run_check("glitch", -1);

        fill_const(0, 0, 0);
        samp[5][0] = 1000;
        samp[14][2] = -1000;
        run_check("settle_viol", -1);

        fill_const(400, 0, -301);
        run_check("persist", -1);

        for (int n = 0; n <= TOT; n++)
            for (int c = 0; c < NC; c++) samp[n][c] = ((n + c) % 2 == 1) ? 300 : -300;
        run_check("bounds", -1);

        fill_const(0, 0, 0);
        lo_v[2] = 5;
        hi_v[2] = -5;
        run_check("inverted", -1);

        set_lims(-300, 300);
        fill_const(0, 0, 0);
        run_check("restart_in_hold", 20);

        for (int r = 0; r < 6; r++) begin
            fill_rand((r % 3 == 0) ? 6 : (r % 3 == 1) ? 60 : 100000);
            run_check("rand", -1);
        end

        set_lims(-300, 300);
        fill_const(0, 0, 0);
        start_run(8, 8);
        chk("abort_settle_busy_before", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_settle_busy", busy, 0);
        chk("abort_settle_done", done, 0);
        dcnt = 0;
        repeat (60) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        chk("abort_settle_no_done", dcnt, 0);
        chk("abort_settle_pass", pass, 0);

        fill_const(0, 0, 999);
        start_run(25, 25);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_hold_busy", busy, 0);
        chk("abort_hold_done", done, 0);
        chk("abort_hold_pass", pass, 0);
        chk("abort_hold_fail_mask", fail_mask, 3'b100);
        chk("abort_hold_first_ch", first_ch, 2);
        chk("abort_hold_viol_kept", viol_cnt != 0, 1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        @(negedge clk);
        chk("start_abort_idle2", busy, 0);

        fill_const(999, 999, 999);
        start_run(25, -1);
        chk("rst_hold_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_fail_mask", fail_mask, 0);
        chk("arst_first_ch", first_ch, 0);
        chk("arst_viol_cnt", viol_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_idle", busy, 0);

`ifdef CONV_MON_ORDER_CHK_EN
        order_en = 1'b1;
        order_en_v = 1'b1;
        set_lims(-300, 300);
        fill_const(50, 60, 0);
        run_check("order_bad", -1);
        fill_const(60, 50, 0);
        run_check("order_ok", -1);
        order_en = 1'b0;
        order_en_v = 1'b0;
`endif

        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 70100; k++) begin
            @(negedge clk);
            if (s_done) begin
                to = 1'b0;
                break;
            end
        end
        chk("sat_timeout", to, 0);
        chk("sat_viol_cnt", s_viol_cnt, 16'hFFFF);
        chk("sat_fail_mask", s_fail_mask, 3'b111);
        chk("sat_first_ch", s_first_ch, 0);
        chk("sat_pass", s_pass, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
